// File: rtl/proc_sequencer.sv
// Multi-cycle control sequencer for the basic processor datapath: fetch over req/ack,
// decode the 4-bit ALU / 3-bit control opcode map, and strobe PC, IR, ALU and register file.
module proc_sequencer #(
    parameter int CNT_W         = 16,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start,
    input  logic             imem_ack,
    input  logic [8:0]       instr,
    input  logic             zero_flag,
    output logic             imem_req,
    output logic             ir_load,
    output logic             pc_rst,
    output logic             pc_inc,
    output logic             pc_load,
    output logic [2:0]       alu_op,
    output logic             reg_we,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_RSH = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_CLR = 3'd4;
    localparam logic [2:0] OP_J   = 3'd5;
    localparam logic [2:0] OP_BRE = 3'd6;

    localparam int WAIT_W = $clog2(FETCH_TIMEOUT + 1);

    logic [2:0]        state_q, state_d;
    logic [3:0]        ir_op;      // instr[8:5]; the low bits only matter for the halt word
    logic              ir_halt;
    logic [2:0]        op;
    logic [WAIT_W-1:0] wait_cnt;
    logic [2:0]        dec_op;
    logic              dec_bad;
    logic              launch, fetch_done, timeout, branch_op, retire;

    // The halt word 9'h1FF would otherwise decode as CLR, so it is flagged separately.
    always_comb begin
        dec_op  = OP_ADD;
        dec_bad = 1'b0;
        if (!ir_op[3]) begin
            case (ir_op[2:0])
                3'b000:  dec_op = OP_RSH;
                3'b001:  dec_op = OP_XOR;
                3'b010:  dec_op = OP_ADD;
                3'b011:  dec_op = OP_AND;
                default: dec_bad = 1'b1;
            endcase
        end else begin
            case (ir_op[2:1])
                2'b00:   dec_op = OP_BRE;
                2'b10:   dec_op = OP_J;
                2'b11:   dec_op = OP_CLR;
                default: dec_bad = 1'b1;
            endcase
        end
    end

    assign launch     = (state_q == S_IDLE || state_q == S_HALT) && start;
    assign fetch_done = (state_q == S_FETCH) && imem_ack;
    assign timeout    = (state_q == S_FETCH) && !imem_ack
                        && (wait_cnt == WAIT_W'(FETCH_TIMEOUT - 1));
    assign branch_op  = (op == OP_J) || (op == OP_BRE);
    assign retire     = ((state_q == S_EXEC) && branch_op) || (state_q == S_WB);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALT: if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack)     state_d = S_DECODE;
                else if (timeout) state_d = S_HALT;
            end
            S_DECODE: state_d = (ir_halt || dec_bad) ? S_HALT : S_EXEC;
            S_EXEC:   state_d = branch_op ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobes are suppressed while Reset is low so an aborted instruction leaves no trace.
    always_comb begin
        imem_req = 1'b0;
        ir_load  = 1'b0;
        pc_rst   = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        alu_op   = 3'd0;
        reg_we   = 1'b0;
        if (Reset) begin
            case (state_q)
                S_IDLE, S_HALT: pc_rst = start;
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_load  = imem_ack;
                end
                S_EXEC: begin
                    alu_op = op;
                    if (op == OP_BRE) begin
                        pc_load = zero_flag;
                        pc_inc  = !zero_flag;
                    end else if (op == OP_J) begin
                        pc_load = 1'b1;
                    end
                end
                S_WB: begin
                    alu_op = op;
                    reg_we = 1'b1;
                    pc_inc = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state_q != S_IDLE) && (state_q != S_HALT);
    assign done  = (state_q == S_HALT);
    assign state = state_q;

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            ir_op    <= 4'd0;
            ir_halt  <= 1'b0;
            op       <= OP_ADD;
            wait_cnt <= '0;
            err_code <= 2'b00;
            retired  <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_FETCH) && !imem_ack) wait_cnt <= wait_cnt + WAIT_W'(1);
            else                                    wait_cnt <= '0;
            if (fetch_done) begin
                ir_op   <= instr[8:5];
                ir_halt <= (instr == 9'h1FF);
            end
            if (state_q == S_DECODE) op <= dec_op;
            if (launch)
                err_code <= 2'b00;
            else if (timeout)
                err_code <= 2'b10;
            else if ((state_q == S_DECODE) && !ir_halt && dec_bad)
                err_code <= 2'b01;
            if (launch)
                retired <= '0;
            else if (retire && (retired != {CNT_W{1'b1}}))
                retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: directed programs plus a randomized instruction stream,
// each cycle compared against a per-instruction model built from the opcode table.
module tb_proc_sequencer;

    localparam int CNT_W   = 4;
    localparam int RET_MAX = (1 << CNT_W) - 1;
    localparam int PW      = 13 + CNT_W;

    logic             CLK;
    logic             Reset;
    logic             start;
    logic             imem_ack;
    logic [8:0]       instr;
    logic             zero_flag;
    logic             imem_req, ir_load, pc_rst, pc_inc, pc_load, reg_we, busy, done;
    logic [2:0]       alu_op;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] retired;
    logic [2:0]       state;

    proc_sequencer #(.CNT_W(CNT_W), .FETCH_TIMEOUT(15)) dut (
        .CLK(CLK), .Reset(Reset), .start(start), .imem_ack(imem_ack), .instr(instr),
        .zero_flag(zero_flag), .imem_req(imem_req), .ir_load(ir_load), .pc_rst(pc_rst),
        .pc_inc(pc_inc), .pc_load(pc_load), .alu_op(alu_op), .reg_we(reg_we), .busy(busy),
        .done(done), .err_code(err_code), .retired(retired), .state(state)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_assert = 0;
    int n_fail   = 0;
    int exp_ret  = 0;
    int exp_err  = 0;
    int mode     = 0;      // 0 idle, 1 running, 2 halted

    // Opcode table: -2 halt word, -1 illegal, otherwise the alu_op code.
    function automatic int exp_code(input logic [8:0] ins);
        int alu_map[4] = '{1, 2, 0, 3};
        int ctl_map[4] = '{6, -1, 5, 4};
        int v;
        v = int'(ins);
        if (v == 511) return -2;
        if (v < 256) return (v / 32 < 4) ? alu_map[v / 32] : -1;
        return ctl_map[v / 64 - 4];
    endfunction

    function automatic logic [31:0] pack(input bit req, input bit irl, input bit pcr,
                                         input bit inc, input bit ld, input int op,
                                         input bit we, input bit bsy, input bit dn,
                                         input int err, input int ret);
        logic [31:0] v;
        v = '0;
        v[PW-1:0] = {req, irl, pcr, inc, ld, op[2:0], we, bsy, dn, err[1:0], ret[CNT_W-1:0]};
        return v;
    endfunction

    function automatic bit rb();
        return ($urandom_range(0, 1) == 1);
    endfunction

    function automatic logic [8:0] rw();
        return 9'($urandom_range(0, 511));
    endfunction

    task automatic check(input string tag, input logic [31:0] exp);
        logic [31:0] obs;
        obs = '0;
        obs[PW-1:0] = {imem_req, ir_load, pc_rst, pc_inc, pc_load, alu_op, reg_we, busy,
                       done, err_code, retired};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit st, input bit ack, input logic [8:0] ins, input bit zf);
        @(negedge CLK);
        start     = st;
        imem_ack  = ack;
        instr     = ins;
        zero_flag = zf;
        #1;
    endtask

    task automatic retire_one();
        if (exp_ret < RET_MAX) exp_ret++;
    endtask

    task automatic do_start(input string tag);
        cyc(1'b1, rb(), rw(), rb());
        check(tag, pack(0, 0, 1, 0, 0, 0, 0, 0, mode == 2, exp_err, exp_ret));
        exp_ret = 0;
        exp_err = 0;
        mode    = 1;
    endtask

    task automatic halt_cycle(input string tag);
        cyc(1'b0, rb(), rw(), rb());
        check(tag, pack(0, 0, 0, 0, 0, 0, 0, 0, 1, exp_err, exp_ret));
    endtask

    // One instruction: `delay` idle FETCH cycles before the ack; 15 or more means no ack.
    task automatic run(input logic [8:0] ins, input int delay, input bit zf);
        int  code;
        bit  a;
        for (int d = 0; d < 15; d++) begin
            a = (d == delay);
            cyc(rb(), a, a ? ins : rw(), rb());
            check($sformatf("fetch%0d_%h", d, ins), pack(1, a, 0, 0, 0, 0, 0, 1, 0, exp_err, exp_ret));
            if (a) break;
        end
        if (delay >= 15) begin
            exp_err = 2;
            mode    = 2;
            return;
        end
        cyc(rb(), rb(), rw(), rb());
        check($sformatf("decode_%h", ins), pack(0, 0, 0, 0, 0, 0, 0, 1, 0, exp_err, exp_ret));
        code = exp_code(ins);
        if (code < 0) begin
            if (code == -1) exp_err = 1;
            mode = 2;
            return;
        end
        cyc(rb(), rb(), rw(), zf);
        if (code == 6) begin
            check($sformatf("exec_bre_z%0d", zf), pack(0, 0, 0, !zf, zf, 6, 0, 1, 0, exp_err, exp_ret));
            retire_one();
            return;
        end
        if (code == 5) begin
            check("exec_j", pack(0, 0, 0, 0, 1, 5, 0, 1, 0, exp_err, exp_ret));
            retire_one();
            return;
        end
        check($sformatf("exec_%h", ins), pack(0, 0, 0, 0, 0, code, 0, 1, 0, exp_err, exp_ret));
        cyc(rb(), rb(), rw(), rb());
        check($sformatf("wb_%h", ins), pack(0, 0, 0, 1, 0, code, 1, 1, 0, exp_err, exp_ret));
        retire_one();
    endtask

    initial begin
        logic [8:0] ins;
        int         k;
        int         dly;
        Reset = 1'b0; start = 1'b0; imem_ack = 1'b0; instr = '0; zero_flag = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("reset", pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        Reset = 1'b1;
        cyc(1'b0, 1'b0, '0, 1'b0);
        check("idle", pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        do_start("start_alu");
        run(9'b0010_00000, 0, rb());
        run(9'b0001_00000, 0, rb());
        run(9'h1FF, 0, rb());
        halt_cycle("halt_alu");

        do_start("start_bre");
        run(9'b100_000000, 0, 1'b1);
        run(9'b100_000000, 0, 1'b0);
        run(9'h1FF, 0, rb());
        halt_cycle("halt_bre");

        do_start("start_ill4");
        run(9'b0010_00000, 0, rb());
        run(9'b0100_00000, 0, rb());
        halt_cycle("halt_ill4");
        do_start("start_ill3");
        run(9'b101_000000, 0, rb());
        halt_cycle("halt_ill3");

        do_start("start_tmo");
        run(rw(), 15, rb());
        halt_cycle("halt_tmo");
        do_start("start_ack15");
        run(9'b0011_00000, 14, rb());
        run(9'h1FF, 0, rb());
        halt_cycle("halt_ack15");

        do_start("start_sat");
        for (int i = 0; i < RET_MAX + 2; i++) run(9'b110_000000, $urandom_range(0, 2), rb());
        run(9'h1FF, 0, rb());
        halt_cycle("halt_sat");

        do_start("start_rand");
        for (int i = 0; i < 120; i++) begin
            if (mode == 2) begin
                halt_cycle("halt_rand");
                do_start("restart_rand");
            end
            if ($urandom_range(0, 3) != 0) begin
                k = $urandom_range(0, 6);
                if (k < 4) ins = 9'((k << 5) | $urandom_range(0, 31));
                else       ins = 9'(((k == 4 ? 4 : k + 1) << 6) | $urandom_range(0, 63));
            end else begin
                ins = rw();
            end
            dly = ($urandom_range(0, 19) == 0) ? 15 : $urandom_range(0, 3);
            run(ins, dly, rb());
        end
        if (mode == 1) run(9'h1FF, 0, rb());
        halt_cycle("halt_end");

        // Reset asserted in WB of an ADD must abort it and clear the counters.
        do_start("start_rst");
        run(9'b0011_00000, 0, rb());
        cyc(1'b0, 1'b1, 9'b0010_00000, rb());
        check("rst_fetch", pack(1, 1, 0, 0, 0, 0, 0, 1, 0, exp_err, exp_ret));
        cyc(1'b0, 1'b0, rw(), rb());
        check("rst_decode", pack(0, 0, 0, 0, 0, 0, 0, 1, 0, exp_err, exp_ret));
        cyc(1'b0, 1'b0, rw(), rb());
        check("rst_exec", pack(0, 0, 0, 0, 0, 0, 0, 1, 0, exp_err, exp_ret));
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        #1;
        exp_ret = 0;
        exp_err = 0;
        mode    = 0;
        check("rst_hold", pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        Reset = 1'b1;
        cyc(1'b0, rb(), rw(), rb());
        check("rst_release", pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, rb(), rw(), rb());
        check("rst_idle", pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/proc_sequencer.md
Name: proc_sequencer

Overview:
- Multi-cycle control FSM for the basic processor datapath.
- Fetches 9-bit instructions over a req/ack handshake, then decodes the processor opcode map (4-bit ALU ops, 3-bit control ops).
- Drives ALU op select, register write, PC increment/load and IR load, one instruction at a time.
- Sits between the instruction memory, program counter, register file and ALU. Reports completion, faults and a retired-instruction count to the test harness.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- FETCH_TIMEOUT, 15, maximum cycles spent in FETCH without imem_ack before faulting.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-low reset (asserted when 0).
- start  input  1  begin-execution pulse; sampled only in IDLE/HALT.
- imem_ack  input  1  instruction memory has valid data on instr this cycle.
- instr  input  9  instruction word.
- zero_flag  input  1  ALU equality/zero result, valid during EXEC.
- imem_req  output  1  fetch request.
- ir_load  output  1  capture instr into instruction register.
- pc_rst  output  1  reset PC to 0.
- pc_inc  output  1  PC <= PC+1.
- pc_load  output  1  PC <= branch/jump target (target computed by datapath).
- alu_op  output  3  op_mne code: ADD=0, RSH=1, XOR=2, AND=3, CLR=4, J=5, BRE=6.
- reg_we  output  1  register file write enable.
- busy  output  1  high in any state other than IDLE/HALT.
- done  output  1  high while in HALT.
- err_code  output  2  00 none, 01 illegal opcode, 10 fetch timeout.
- retired  output  CNT_W  count of retired instructions.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- Reset (Reset=0 at an edge): next state IDLE. retired=0, err_code=00, decoded op=ADD. All outputs 0. Reset mid-instruction aborts it with no further strobes.
- IDLE: start=1 -> pc_rst=1 for that cycle, clear retired/err_code, go FETCH.
- FETCH: imem_req=1.
  - imem_ack=1 -> ir_load=1 in the same cycle, latch instr, go DECODE.
  - Wait counter reaches FETCH_TIMEOUT cycles without ack -> err_code=10, go HALT.
  - An ack on the final allowed cycle wins over the timeout.
- DECODE (1 cycle, no strobes):
  - instr==9'h1FF -> halt: go HALT, not counted, err_code stays 00.
  - instr[8]=0: op4=instr[8:5]. 0000 RSH, 0001 XOR, 0010 ADD, 0011 AND. 01xx -> err_code=01, go HALT.
  - instr[8]=1: op3=instr[8:6]. 100 BRE, 110 J, 111 CLR. 101 -> err_code=01, go HALT.
  - Valid op -> go EXEC.
- EXEC: alu_op = decoded code.
  - ALU ops and CLR -> go WB.
  - BRE: zero_flag=1 -> pc_load=1, else pc_inc=1. retired++, go FETCH.
  - J: pc_load=1, retired++, go FETCH.
- WB: alu_op held, reg_we=1, pc_inc=1, retired++, go FETCH.
- Latency (ack on first FETCH cycle): ALU/CLR = 4 cycles per instruction; BRE/J = 3 cycles.
- pc_inc and pc_load are never high in the same cycle.
- alu_op = 0 outside EXEC/WB.
- retired saturates at all-ones; never wraps.
- HALT: done=1; err_code and retired held. start=1 -> behaves as from IDLE (pc_rst, clear, FETCH).
- start while busy is ignored.
- imem_ack outside FETCH is ignored.

Test Plan:
- Reset=0 for 2 cycles mid-WB, then Reset=1 -> IDLE next edge, all outputs 0, retired=0, no reg_we after reset.
- start; program ADD (9'b0010_00000), XOR, 9'h1FF with immediate acks -> each ALU instr shows reg_we+pc_inc in cycle 4. done=1, retired=2, err_code=00.
- BRE (9'b100_000000) with zero_flag=1, then BRE with zero_flag=0 -> pc_load pulse in first EXEC, pc_inc pulse in second. Each takes 3 cycles, retired increments by 1 each.
- instr 9'b0100_00000, then separately 9'b101_000000 -> HALT after DECODE, err_code=01, no reg_we/pc strobe, retired unchanged.
- imem_ack withheld for 15 cycles -> err_code=10, done=1. Second run with ack on cycle 15 -> proceeds to DECODE, no fault.
- start pulsed during EXEC -> ignored. start in HALT -> pc_rst pulse, retired=0, err_code=00, FETCH next cycle.
